// File: rtl/idelay_tap_ctrl.sv
// -----------------------------------------------------------------------------
// idelay_tap_ctrl
//
// Run-time tap controller for a bank of WIDTH IDELAYE2 primitives (VAR_LOAD
// mode) on the RGMII RX path. After the shared IDELAYCTRL reports ready, every
// lane is loaded with DEFAULT_TAP and read back. The controller then serves
// load / increment / decrement / reload-all commands over a valid/ready
// interface, reads CNTVALUEOUT back after every change and reports the result.
//
// Ports:
//   clk_200m         sole clock (IDELAYCTRL reference clock)
//   sys_rst          synchronous, active-high reset
//   idelayctrl_rdy   IDELAYCTRL RDY
//   cmd_valid/ready  command handshake; cmd_ready is high only in IDLE
//   cmd_op           00 load, 01 inc, 10 dec, 11 reload all defaults
//   cmd_lane         target lane (ignored for reload-all)
//   cmd_tap          tap value for load
//   resp_valid       one-cycle response pulse, qualifies resp_err/resp_tap
//   resp_err         readback mismatch or rejected command
//   resp_tap         readback tap of the target lane (reload-all: last lane)
//   init_done        default taps applied, serving commands
//   init_err         sticky readback mismatch seen during init
//   dly_ld/dly_ce    per-lane LD / CE pulses (at most one bit high overall)
//   dly_inc          INC level shared by all lanes
//   dly_cntvaluein   CNTVALUEIN shared by all lanes
//   dly_cntvalueout  CNTVALUEOUT bus; lane i at bits [5i+4:5i]
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module idelay_tap_ctrl #(
  parameter int WIDTH         = 4,
  parameter int LANE_W        = 2,
  parameter int DEFAULT_TAP   = 0,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clk_200m,
  input  logic                sys_rst,
  input  logic                idelayctrl_rdy,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [LANE_W-1:0]   cmd_lane,
  input  logic [4:0]          cmd_tap,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [4:0]          resp_tap,
  output logic                init_done,
  output logic                init_err,
  output logic [WIDTH-1:0]    dly_ld,
  output logic [WIDTH-1:0]    dly_ce,
  output logic                dly_inc,
  output logic [4:0]          dly_cntvaluein,
  input  logic [5*WIDTH-1:0]  dly_cntvalueout
);

  localparam logic [3:0] S_WAIT_RDY    = 4'd0;
  localparam logic [3:0] S_INIT_PULSE  = 4'd1;
  localparam logic [3:0] S_INIT_SETTLE = 4'd2;
  localparam logic [3:0] S_INIT_CHECK  = 4'd3;
  localparam logic [3:0] S_IDLE        = 4'd4;
  localparam logic [3:0] S_PULSE       = 4'd5;
  localparam logic [3:0] S_SETTLE      = 4'd6;
  localparam logic [3:0] S_CHECK       = 4'd7;
  localparam logic [3:0] S_RESP        = 4'd8;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_INC    = 2'b01;
  localparam logic [1:0] OP_DEC    = 2'b10;
  localparam logic [1:0] OP_RELOAD = 2'b11;

  localparam logic [4:0]        DEF_TAP     = 5'(DEFAULT_TAP);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(WIDTH - 1);

  // Registered state
  logic [3:0]        state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [1:0]        op_q, op_d;
  logic [4:0]        tap_q, tap_d;
  logic [4:0]        old_q, old_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              reload_q, reload_d;
  logic              any_err_q, any_err_d;
  logic              init_done_q, init_done_d;
  logic              init_err_q, init_err_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [4:0]        resp_tap_q, resp_tap_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [WIDTH-1:0]  dly_ld_q, dly_ld_d;
  logic [WIDTH-1:0]  dly_ce_q, dly_ce_d;
  logic              dly_inc_q, dly_inc_d;
  logic [4:0]        dly_cval_q, dly_cval_d;

  // Combinational helpers
  logic [4:0]        rb_lane;   // readback of the lane being worked on
  logic [4:0]        rb_cmd;    // readback of the lane addressed by cmd_lane
  logic              cmd_lane_ok;
  logic [4:0]        exp_tap;
  logic              mism;
  logic              outstanding;
  logic [WIDTH-1:0]  lane_oh;

  // Out-of-range lanes read back as 0 so a rejected command still reports a
  // defined value.
  function automatic logic [4:0] lane_tap(input logic [5*WIDTH-1:0] bus,
                                          input logic [LANE_W-1:0]  lane);
    logic [4:0] t;
    t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lane == LANE_W'(i)) t = bus[5*i +: 5];
    end
    return t;
  endfunction

  assign rb_lane     = lane_tap(dly_cntvalueout, lane_q);
  assign rb_cmd      = lane_tap(dly_cntvalueout, cmd_lane);
  assign cmd_lane_ok = int'(cmd_lane) < WIDTH;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d      = state_q;
    rdy_d        = idelayctrl_rdy;
    lane_d       = lane_q;
    op_d         = op_q;
    tap_d        = tap_q;
    old_d        = old_q;
    cnt_d        = cnt_q;
    reload_d     = reload_q;
    any_err_d    = any_err_q;
    init_done_d  = init_done_q;
    init_err_d   = init_err_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_tap_d   = 5'd0;
    exp_tap      = tap_q;
    mism         = 1'b0;
    outstanding  = 1'b0;

    case (state_q)
      S_WAIT_RDY: begin
        // Two consecutive high samples of RDY before touching the bank.
        if (idelayctrl_rdy && rdy_q) begin
          state_d   = S_INIT_PULSE;
          lane_d    = '0;
          reload_d  = 1'b0;
          any_err_d = 1'b0;
        end
      end
      S_INIT_PULSE: begin
        state_d = S_INIT_SETTLE;
        cnt_d   = SETTLE_LAST;
      end
      S_INIT_SETTLE: begin
        if (cnt_q == 4'd0) state_d = S_INIT_CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_INIT_CHECK: begin
        mism = (rb_lane != DEF_TAP);
        // A reload-all reports through the response, not through init_err.
        if (mism) begin
          if (reload_q) any_err_d  = 1'b1;
          else          init_err_d = 1'b1;
        end
        if (lane_q == LAST_LANE) begin
          if (reload_q) begin
            state_d      = S_RESP;
            reload_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = any_err_q | mism;
            resp_tap_d   = rb_lane;
          end else begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end
        end else begin
          state_d = S_INIT_PULSE;
          lane_d  = lane_q + LANE_W'(1);
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          lane_d = cmd_lane;
          tap_d = cmd_tap;
          old_d = rb_cmd;
          if (cmd_op == OP_RELOAD) begin
            state_d   = S_INIT_PULSE;
            lane_d    = '0;
            reload_d  = 1'b1;
            any_err_d = 1'b0;
          end else if (!cmd_lane_ok ||
                       (cmd_op == OP_INC && rb_cmd == 5'd31) ||
                       (cmd_op == OP_DEC && rb_cmd == 5'd0)) begin
            // The primitive's counter wraps; never step it past either end.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_tap_d   = rb_cmd;
          end else begin
            state_d = S_PULSE;
          end
        end
      end
      S_PULSE: begin
        state_d = S_SETTLE;
        cnt_d   = SETTLE_LAST;
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) state_d = S_CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_CHECK: begin
        case (op_q)
          OP_INC:  exp_tap = old_q + 5'd1;
          OP_DEC:  exp_tap = old_q - 5'd1;
          default: exp_tap = tap_q;
        endcase
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = (rb_lane != exp_tap);
        resp_tap_d   = rb_lane;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_WAIT_RDY;
      end
    endcase

    // Losing IDELAYCTRL ready aborts whatever is running; an accepted command
    // still gets exactly one (failed) response.
    if (state_q != S_WAIT_RDY && !idelayctrl_rdy) begin
      outstanding = (state_q == S_PULSE) || (state_q == S_SETTLE) ||
                    (state_q == S_CHECK) ||
                    (reload_q && ((state_q == S_INIT_PULSE) ||
                                  (state_q == S_INIT_SETTLE) ||
                                  (state_q == S_INIT_CHECK)));
      state_d      = S_WAIT_RDY;
      init_done_d  = 1'b0;
      reload_d     = 1'b0;
      resp_valid_d = outstanding;
      resp_err_d   = outstanding;
      resp_tap_d   = outstanding ? rb_lane : 5'd0;
    end

    // Bank-side outputs are decoded from the next state so they leave the
    // block straight from flops.
    for (int i = 0; i < WIDTH; i++) lane_oh[i] = (lane_d == LANE_W'(i));
    cmd_ready_d = (state_d == S_IDLE);
    dly_ld_d    = '0;
    dly_ce_d    = '0;
    dly_inc_d   = 1'b0;
    dly_cval_d  = 5'd0;
    if (state_d == S_INIT_PULSE) begin
      dly_ld_d   = lane_oh;
      dly_cval_d = DEF_TAP;
    end else if (state_d == S_PULSE) begin
      if (op_d == OP_LOAD) begin
        dly_ld_d   = lane_oh;
        dly_cval_d = tap_d;
      end else begin
        dly_ce_d  = lane_oh;
        dly_inc_d = (op_d == OP_INC);
      end
    end
  end

  always_ff @(posedge clk_200m) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (sys_rst) begin
      state_q      <= S_WAIT_RDY;
      rdy_q        <= 1'b0;
      lane_q       <= '0;
      op_q         <= 2'b00;
      tap_q        <= 5'd0;
      old_q        <= 5'd0;
      cnt_q        <= 4'd0;
      reload_q     <= 1'b0;
      any_err_q    <= 1'b0;
      init_done_q  <= 1'b0;
      init_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_tap_q   <= 5'd0;
      cmd_ready_q  <= 1'b0;
      dly_ld_q     <= '0;
      dly_ce_q     <= '0;
      dly_inc_q    <= 1'b0;
      dly_cval_q   <= 5'd0;
    end else begin
      state_q      <= state_d;
      rdy_q        <= rdy_d;
      lane_q       <= lane_d;
      op_q         <= op_d;
      tap_q        <= tap_d;
      old_q        <= old_d;
      cnt_q        <= cnt_d;
      reload_q     <= reload_d;
      any_err_q    <= any_err_d;
      init_done_q  <= init_done_d;
      init_err_q   <= init_err_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_tap_q   <= resp_tap_d;
      cmd_ready_q  <= cmd_ready_d;
      dly_ld_q     <= dly_ld_d;
      dly_ce_q     <= dly_ce_d;
      dly_inc_q    <= dly_inc_d;
      dly_cval_q   <= dly_cval_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_tap       = resp_tap_q;
  assign init_done      = init_done_q;
  assign init_err       = init_err_q;
  assign dly_ld         = dly_ld_q;
  assign dly_ce         = dly_ce_q;
  assign dly_inc        = dly_inc_q;
  assign dly_cntvaluein = dly_cval_q;

endmodule

// File: tb/tb_idelay_tap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_idelay_tap_ctrl
//
// Self-checking bench for idelay_tap_ctrl. A small IDELAYE2 model echoes
// LD/CE activity on CNTVALUEOUT (lane 3 can be forced stuck at 3). Directed
// command vectors live in a table; init, back-to-back, RDY loss and mid-run
// reset are hand-written sequences.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_idelay_tap_ctrl;

  localparam int WIDTH  = 4;
  localparam int LANE_W = 3;
  localparam int DEF    = 5;
  localparam int SETTLE = 4;
  localparam int LAT    = SETTLE + 2;
  localparam int NV     = 12;

  logic                clk_200m = 1'b0;
  logic                sys_rst;
  logic                idelayctrl_rdy;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [LANE_W-1:0]   cmd_lane;
  logic [4:0]          cmd_tap;
  logic                resp_valid;
  logic                resp_err;
  logic [4:0]          resp_tap;
  logic                init_done;
  logic                init_err;
  logic [WIDTH-1:0]    dly_ld;
  logic [WIDTH-1:0]    dly_ce;
  logic                dly_inc;
  logic [4:0]          dly_cntvaluein;
  logic [5*WIDTH-1:0]  dly_cntvalueout;

  always #2.5 clk_200m = ~clk_200m;

  idelay_tap_ctrl #(
    .WIDTH(WIDTH), .LANE_W(LANE_W), .DEFAULT_TAP(DEF), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk_200m(clk_200m), .sys_rst(sys_rst), .idelayctrl_rdy(idelayctrl_rdy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_lane(cmd_lane), .cmd_tap(cmd_tap), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_tap(resp_tap), .init_done(init_done),
    .init_err(init_err), .dly_ld(dly_ld), .dly_ce(dly_ce), .dly_inc(dly_inc),
    .dly_cntvaluein(dly_cntvaluein), .dly_cntvalueout(dly_cntvalueout)
  );

  // ---------------- IDELAY bank model ----------------
  logic [4:0] model_tap [WIDTH];
  logic       stuck3 = 1'b0;

  always @(posedge clk_200m) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (sys_rst)        model_tap[i] <= 5'd0;
      else if (dly_ld[i]) model_tap[i] <= dly_cntvaluein;
      else if (dly_ce[i]) model_tap[i] <= dly_inc ? model_tap[i] + 5'd1 : model_tap[i] - 5'd1;
    end
  end

  always_comb begin
    dly_cntvalueout = '0;
    for (int i = 0; i < WIDTH; i++)
      dly_cntvalueout[5*i +: 5] = (i == 3 && stuck3) ? 5'd3 : model_tap[i];
  end

  // ---------------- activity monitor ----------------
  int               cyc, ld_cnt, ce_cnt, resp_cnt, viol_cnt;
  logic [WIDTH-1:0] last_ld_mask;
  logic [4:0]       last_ld_val;
  logic             last_ce_inc;
  int               ld_time [$];
  logic [WIDTH-1:0] ld_mask_q [$];

  always @(posedge clk_200m) begin
    cyc <= cyc + 1;
    if (|dly_ld) begin
      ld_cnt       <= ld_cnt + $countones(dly_ld);
      last_ld_mask <= dly_ld;
      last_ld_val  <= dly_cntvaluein;
      ld_time.push_back(cyc);
      ld_mask_q.push_back(dly_ld);
    end
    if (|dly_ce) begin
      ce_cnt      <= ce_cnt + $countones(dly_ce);
      last_ce_inc <= dly_inc;
    end
    if ($countones(dly_ld) + $countones(dly_ce) > 1) viol_cnt <= viol_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [23:0] all_outputs();
    return {cmd_ready, resp_valid, resp_err, resp_tap, init_done, init_err,
            dly_ld, dly_ce, dly_inc, dly_cntvaluein};
  endfunction

  function automatic logic [5*WIDTH-1:0] model_packed();
    logic [5*WIDTH-1:0] p;
    for (int i = 0; i < WIDTH; i++) p[5*i +: 5] = model_tap[i];
    return p;
  endfunction

  task automatic wait_init(input string name);
    for (int i = 0; i < 300; i++) begin
      if (init_done) break;
      @(posedge clk_200m); #1;
    end
    check(name, init_done, 1);
  endtask

  // Init pulses since queue index base: one per lane, in order, LAT apart.
  task automatic check_init_pulses(input string name, input int base);
    int bad_sp, bad_m;
    logic [WIDTH-1:0] m;
    bad_sp = 0;
    bad_m  = 0;
    check({name, "_ld_count"}, ld_time.size() - base, WIDTH);
    for (int i = 0; i < WIDTH && base + i < ld_time.size(); i++) begin
      m = '0;
      m[i] = 1'b1;
      if (ld_mask_q[base + i] != m) bad_m++;
      if (i > 0 && ld_time[base + i] - ld_time[base + i - 1] != LAT) bad_sp++;
    end
    check({name, "_ld_order"}, bad_m, 0);
    check({name, "_ld_spacing"}, bad_sp, 0);
  endtask

  // Issue one command; lat counts clock edges from the accept edge to the edge
  // that raises resp_valid (0 = response in the cycle right after accept).
  task automatic do_cmd(input logic [1:0] op, input logic [LANE_W-1:0] lane,
                        input logic [4:0] tap, output logic err,
                        output logic [4:0] rtap, output int lat,
                        output int nld, output int nce);
    int ld0, ce0;
    err = 1'bx; rtap = 5'bx; lat = -1; nld = -1; nce = -1;
    @(negedge clk_200m);
    cmd_valid = 1'b1; cmd_op = op; cmd_lane = lane; cmd_tap = tap;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) break;
      @(negedge clk_200m);
    end
    if (!cmd_ready) begin
      check("accept_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    ld0 = ld_cnt;
    ce0 = ce_cnt;
    @(posedge clk_200m); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (resp_valid) begin
        lat = k;
        break;
      end
      @(posedge clk_200m); #1;
    end
    err  = resp_err;
    rtap = resp_tap;
    nld  = ld_cnt - ld0;
    nce  = ce_cnt - ce0;
  endtask

  typedef struct {
    logic [1:0]        op;
    logic [LANE_W-1:0] lane;
    logic [4:0]        tap;
    logic              err;
    logic [4:0]        rtap;
    int                lat;
    int                nld;
    int                nce;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       err;
    logic [4:0] rtap;
    int         lat, nld, nce, base, r0;
    logic [WIDTH-1:0] m;

    //            op     lane  tap    err   rtap   lat  nld nce
    vecs[0]  = '{2'd0, 3'd2, 5'd17, 1'b0, 5'd17, LAT, 1, 0};  // load lane 2
    vecs[1]  = '{2'd0, 3'd1, 5'd31, 1'b0, 5'd31, LAT, 1, 0};
    vecs[2]  = '{2'd1, 3'd1, 5'd0,  1'b1, 5'd31, 0,   0, 0};  // inc at 31: reject
    vecs[3]  = '{2'd0, 3'd1, 5'd0,  1'b0, 5'd0,  LAT, 1, 0};
    vecs[4]  = '{2'd2, 3'd1, 5'd0,  1'b1, 5'd0,  0,   0, 0};  // dec at 0: reject
    vecs[5]  = '{2'd0, 3'd0, 5'd9,  1'b0, 5'd9,  LAT, 1, 0};
    vecs[6]  = '{2'd2, 3'd0, 5'd0,  1'b0, 5'd8,  LAT, 0, 1};  // dec 9 -> 8
    vecs[7]  = '{2'd1, 3'd0, 5'd0,  1'b0, 5'd9,  LAT, 0, 1};  // inc 8 -> 9
    vecs[8]  = '{2'd0, 3'd5, 5'd7,  1'b1, 5'd0,  0,   0, 0};  // lane 5 out of range
    vecs[9]  = '{2'd1, 3'd7, 5'd0,  1'b1, 5'd0,  0,   0, 0};  // lane 7 out of range
    vecs[10] = '{2'd3, 3'd0, 5'd0,  1'b0, 5'd5,  4*LAT, 4, 0}; // reload all
    vecs[11] = '{2'd1, 3'd2, 5'd0,  1'b0, 5'd6,  LAT, 0, 1};  // 5 -> 6 after reload

    // ---- reset ----
    sys_rst = 1'b1; idelayctrl_rdy = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_lane = '0; cmd_tap = 5'd0;
    repeat (3) @(posedge clk_200m);
    #1;
    check("reset_outputs", all_outputs(), 0);
    sys_rst = 1'b0;
    repeat (10) @(posedge clk_200m);
    #1;
    check("wait_rdy_no_ready", {cmd_ready, init_done, |dly_ld}, 0);

    // ---- init after RDY ----
    base = ld_time.size();
    idelayctrl_rdy = 1'b1;
    wait_init("init_done");
    check_init_pulses("init", base);
    check("init_err_clean", init_err, 0);
    check("init_cmd_ready", cmd_ready, 1);
    check("init_model_taps", model_packed(), {WIDTH{5'(DEF)}});

    // ---- command table ----
    for (int v = 0; v < NV; v++) begin
      do_cmd(vecs[v].op, vecs[v].lane, vecs[v].tap, err, rtap, lat, nld, nce);
      check($sformatf("v%0d_err", v), err, vecs[v].err);
      check($sformatf("v%0d_tap", v), rtap, vecs[v].rtap);
      check($sformatf("v%0d_lat", v), lat, vecs[v].lat);
      check($sformatf("v%0d_nld", v), nld, vecs[v].nld);
      check($sformatf("v%0d_nce", v), nce, vecs[v].nce);
      if (vecs[v].op == 2'd0 && vecs[v].nld == 1) begin
        m = '0;
        m[int'(vecs[v].lane)] = 1'b1;
        check($sformatf("v%0d_ld_mask", v), last_ld_mask, m);
        check($sformatf("v%0d_ld_val", v), last_ld_val, vecs[v].tap);
      end
      if (vecs[v].nce == 1)
        check($sformatf("v%0d_inc_level", v), last_ce_inc, vecs[v].op == 2'd1);
    end

    // ---- back-to-back with cmd_valid held ----
    @(negedge clk_200m);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_lane = 3'd0; cmd_tap = 5'd12;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk_200m);
    @(posedge clk_200m); #1;                 // first accepted
    cmd_lane = 3'd1; cmd_tap = 5'd13;        // second command, valid stays high
    lat = -1;
    for (int k = 0; k < 50; k++) begin
      if (resp_valid) begin lat = k; break; end
      @(posedge clk_200m); #1;
    end
    check("b2b_first_lat", lat, LAT);
    check("b2b_first_tap", resp_tap, 12);
    check("b2b_ready_in_resp", cmd_ready, 0);
    @(posedge clk_200m); #1;
    check("b2b_ready_back", cmd_ready, 1);
    @(posedge clk_200m); #1;                 // second accepted on this edge
    cmd_valid = 1'b0;
    check("b2b_ready_after_accept", cmd_ready, 0);
    lat = -1;
    for (int k = 0; k < 50; k++) begin
      if (resp_valid) begin lat = k; break; end
      @(posedge clk_200m); #1;
    end
    check("b2b_second_lat", lat, LAT);
    check("b2b_second_tap_err", {resp_err, resp_tap}, {1'b0, 5'd13});

    // ---- RDY lost during SETTLE of an inc ----
    @(negedge clk_200m);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_lane = 3'd0; cmd_tap = 5'd0;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk_200m);
    @(posedge clk_200m); #1;                 // accept
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk_200m);
    #1;                                      // now in SETTLE
    r0 = resp_cnt;
    idelayctrl_rdy = 1'b0;
    @(posedge clk_200m); #1;
    check("rdy_drop_resp", {resp_valid, resp_err}, 2'b11);
    check("rdy_drop_init_done", init_done, 0);
    repeat (10) @(posedge clk_200m);
    #1;
    check("rdy_drop_single_resp", resp_cnt - r0, 1);
    check("rdy_drop_no_ready", cmd_ready, 0);
    base = ld_time.size();
    idelayctrl_rdy = 1'b1;
    wait_init("reinit_done");
    check_init_pulses("reinit", base);
    check("reinit_model_taps", model_packed(), {WIDTH{5'(DEF)}});

    // ---- stuck lane 3 during init ----
    @(negedge clk_200m);
    sys_rst = 1'b1; stuck3 = 1'b1;
    @(negedge clk_200m);
    sys_rst = 1'b0;
    wait_init("stuck_init_done");
    check("stuck_init_err", init_err, 1);
    do_cmd(2'd0, 3'd3, 5'd3, err, rtap, lat, nld, nce);
    check("stuck_load3", {err, rtap}, {1'b0, 5'd3});
    check("stuck_load3_lat", lat, LAT);
    do_cmd(2'd3, 3'd0, 5'd0, err, rtap, lat, nld, nce);
    check("stuck_reload", {err, rtap}, {1'b1, 5'd3});
    check("stuck_flags_kept", {init_done, init_err}, 2'b11);

    // ---- sys_rst mid-command: no response, all outputs cleared ----
    @(negedge clk_200m);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_lane = 3'd0; cmd_tap = 5'd10;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk_200m);
    @(posedge clk_200m); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk_200m);
    #1;
    r0 = resp_cnt;
    sys_rst = 1'b1;
    @(posedge clk_200m); #1;
    check("midrst_outputs", all_outputs(), 0);
    sys_rst = 1'b0; stuck3 = 1'b0;
    repeat (10) @(posedge clk_200m);
    #1;
    check("midrst_no_resp", resp_cnt - r0, 0);

    check("ld_ce_exclusive", viol_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
